// File: rtl/melody_pkg.sv
// Shared note codes, frequency table, song ROM and tone-period helpers for melody_player.
package melody_pkg;

  // 0 = rest, 1-7 low DO..XI, 8-14 mid DO..XI, 15-21 high DO..XI
  typedef logic [4:0] note_t;

  typedef enum logic [0:0] {
    StIdle,
    StPlay
  } state_e;

  localparam int unsigned NumCodes = 22;
  localparam int unsigned RomSongs = 2;
  localparam int unsigned RomLen   = 8;
  localparam int unsigned LowestHz = 262;

  localparam int unsigned NoteHz [NumCodes] = '{
    0,
    262, 294, 330, 349, 392, 440, 494,
    523, 587, 659, 698, 784, 880, 988,
    1047, 1175, 1319, 1397, 1568, 1760, 1976
  };

  // Song 0: hourly chime; song 1: alarm.
  localparam int unsigned SongRom [RomSongs][RomLen] = '{
    '{6, 7, 8, 9, 10, 10, 14, 13},
    '{15, 0, 15, 0, 15, 0, 15, 0}
  };

  function automatic int unsigned note_hz(input int unsigned code);
    return (code < NumCodes) ? NoteHz[code] : 0;
  endfunction

  // Half-period in clocks (integer floor); 0 for a rest.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned code);
    int unsigned hz;
    hz = note_hz(code);
    return (hz == 0) ? 0 : clk_hz / (2 * hz);
  endfunction

  function automatic int unsigned max_half(input int unsigned clk_hz);
    return clk_hz / (2 * LowestHz);
  endfunction

  // Song or note indices beyond the ROM wrap around onto the stored tunes.
  function automatic int unsigned song_note(input int unsigned song, input int unsigned idx);
    return SongRom[song % RomSongs][idx % RomLen];
  endfunction

endpackage

// File: rtl/melody_player_tone_gen.sv
// Square-wave generator: toggles every half_i clocks while enabled, phase cleared by clr_i.
module tone_gen #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] half_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic             wave_o
);

  logic [Width-1:0] cnt_q;
  logic             wave_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || !en_i) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (cnt_q == half_i - Width'(1)) begin
      cnt_q  <= '0;
      wave_q <= ~wave_q;
    end else begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign wave_o = wave_q;

endmodule

// File: rtl/melody_player.sv
// Melody player: plays one of SONG_NUM ROM melodies as a square wave on b_eep.
// Optional NOTE_GAP_EN silences the last GAP_TICKS clocks of every note.
module melody_player
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned NOTE_TICKS = 50_000_000,
  parameter int unsigned MELODY_LEN = 8,
  parameter int unsigned SONG_NUM   = 2,
  parameter int unsigned GAP_TICKS  = 5_000_000,
  localparam int unsigned SelW      = (SONG_NUM > 1) ? $clog2(SONG_NUM) : 1,
  localparam int unsigned StepW     = $clog2(MELODY_LEN)
) (
  input  logic             clk50mhz,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [SelW-1:0]  song_sel,
  output logic             b_eep,
  output logic             busy,
  output logic             done,
  output logic [StepW-1:0] step
);

  localparam int unsigned NoteW   = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam int unsigned MaxHalf = max_half(CLK_HZ);
  localparam int unsigned TW      = (MaxHalf > 1) ? $clog2(MaxHalf + 1) : 1;

  if (MELODY_LEN < 2) begin : g_bad_len
    $error("MELODY_LEN must be at least 2");
  end
  if (GAP_TICKS >= NOTE_TICKS) begin : g_bad_gap
    $error("GAP_TICKS must be smaller than NOTE_TICKS");
  end

  state_e           state_q;
  logic [SelW-1:0]  song_q;
  logic [SelW-1:0]  song_lat;
  logic [NoteW-1:0] note_cnt_q;
  logic [StepW-1:0] step_q;
  logic             busy_q;
  logic             done_q;

  note_t            note_rom [SONG_NUM][MELODY_LEN];
  logic [TW-1:0]    half_rom [SONG_NUM][MELODY_LEN];
  note_t            cur_note;
  logic [TW-1:0]    cur_half;

  logic             playing;
  logic             note_last;
  logic             song_last;
  logic             gap;
  logic             tone_en;
  logic             tone_clr;

  // Note codes and half-periods are resolved entirely at elaboration.
  for (genvar s = 0; s < SONG_NUM; s++) begin : g_song
    for (genvar i = 0; i < MELODY_LEN; i++) begin : g_note
      assign note_rom[s][i] = note_t'(song_note(s, i));
      assign half_rom[s][i] = TW'(half_period(CLK_HZ, song_note(s, i)));
    end
  end

  if (SONG_NUM == (1 << SelW)) begin : g_sel_full
    assign song_lat = song_sel;
  end else begin : g_sel_clip
    assign song_lat = (song_sel < SelW'(SONG_NUM)) ? song_sel : '0;
  end

  assign cur_note  = note_rom[song_q][step_q];
  assign cur_half  = half_rom[song_q][step_q];
  assign playing   = (state_q == StPlay);
  assign note_last = (note_cnt_q == NoteW'(NOTE_TICKS - 1));
  assign song_last = (step_q == StepW'(MELODY_LEN - 1));

`ifdef NOTE_GAP_EN
  // Starts one tick early so the registered b_eep is already low on the first gap clock.
  localparam int unsigned GapStart = NOTE_TICKS - GAP_TICKS - 1;
  assign gap = (note_cnt_q >= NoteW'(GapStart));
`else
  assign gap = 1'b0;
`endif

  assign tone_en  = playing && (cur_note != '0) && !gap;
  assign tone_clr = stop || start || (playing && note_last);

  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      state_q    <= StIdle;
      song_q     <= '0;
      note_cnt_q <= '0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q    <= StIdle;
        note_cnt_q <= '0;
        step_q     <= '0;
        busy_q     <= 1'b0;
      end else if (start) begin
        // Also the retrigger path; it outranks a natural song end on the same tick.
        state_q    <= StPlay;
        song_q     <= song_lat;
        note_cnt_q <= '0;
        step_q     <= '0;
        busy_q     <= 1'b1;
      end else if (playing) begin
        if (note_last) begin
          note_cnt_q <= '0;
          if (song_last) begin
            state_q <= StIdle;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            step_q <= step_q + StepW'(1);
          end
        end else begin
          note_cnt_q <= note_cnt_q + NoteW'(1);
        end
      end
    end
  end

  tone_gen #(
    .Width (TW)
  ) u_tone_gen (
    .clk_i  (clk50mhz),
    .rst_i  (rst),
    .half_i (cur_half),
    .en_i   (tone_en),
    .clr_i  (tone_clr),
    .wave_o (b_eep)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;

endmodule

// File: tb/tb_melody_player.sv
// Scoreboard bench for melody_player: timed expectations and done pulses are queued by the
// stimulus and consumed by an independent negedge monitor.
module tb_melody_player;

  localparam int unsigned ClkHz     = 100_000;
  localparam int unsigned NoteTicks = 1000;
  localparam int unsigned MelLen    = 8;
  localparam int unsigned SongNum   = 2;
  localparam int unsigned GapTicks  = 100;

  // Hand-computed half-periods at 100 kHz: low LA 113, mid DO 95, mid MI 75, high DO 47.

  logic       clk50mhz = 1'b0;
  logic       rst      = 1'b1;
  logic       start    = 1'b0;
  logic       stop     = 1'b0;
  logic [0:0] song_sel = 1'b0;
  logic       b_eep;
  logic       busy;
  logic       done;
  logic [2:0] step;

  melody_player #(
    .CLK_HZ     (ClkHz),
    .NOTE_TICKS (NoteTicks),
    .MELODY_LEN (MelLen),
    .SONG_NUM   (SongNum),
    .GAP_TICKS  (GapTicks)
  ) dut (
    .clk50mhz (clk50mhz),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .song_sel (song_sel),
    .b_eep    (b_eep),
    .busy     (busy),
    .done     (done),
    .step     (step)
  );

  initial forever #5 clk50mhz = ~clk50mhz;

  int cyc = 0;
  always @(posedge clk50mhz) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Expectation scoreboard kept sorted by cycle; beep < 0 means not checked.
  int    qc[$];
  string qn[$];
  int    qb[$];
  int    qs[$];
  int    qe[$];
  int    dq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at cycle %0d", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input string nm, input int b, input int s, input int e);
    int i = 0;
    while (i < qc.size() && qc[i] <= c) i++;
    qc.insert(i, c);
    qn.insert(i, nm);
    qb.insert(i, b);
    qs.insert(i, s);
    qe.insert(i, e);
  endtask

  int    mc, mb, ms, me, md;
  string mn;

  always @(negedge clk50mhz) begin
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got pulse at cycle %0d, required none", cyc);
      end else begin
        md = dq.pop_front();
        chk("done_cycle", cyc, md);
      end
    end
    while (qc.size() > 0 && qc[0] <= cyc) begin
      mc = qc.pop_front();
      mn = qn.pop_front();
      mb = qb.pop_front();
      ms = qs.pop_front();
      me = qe.pop_front();
      if (mc != cyc) begin
        chk({mn, "_missed"}, cyc, mc);
      end else begin
        chk({mn, "_busy"}, 32'(busy), mb);
        chk({mn, "_step"}, 32'(step), ms);
        if (me >= 0) chk({mn, "_beep"}, 32'(b_eep), me);
      end
    end
  end

  task automatic tick();
    @(posedge clk50mhz);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Returns the first cycle in which busy is expected high.
  task automatic do_start(input logic sel, output int s);
    song_sel = sel;
    start    = 1'b1;
    s        = cyc + 1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    int s, r, p;

    rst = 1'b1;
    tick();
    tick();
    push(cyc, "reset", 0, 0, 0);
    rst = 1'b0;
    tick();
    push(cyc, "idle_after_reset", 0, 0, 0);
    tick();

    // Song 0 end to end: timing, first note tone, MI MI boundary.
    push(cyc, "t1_pre", 0, 0, 0);
    do_start(1'b0, s);
    for (int k = 0; k < 8; k++) begin
      push(s + k * 1000, "t1_step_start", 1, k, -1);
      push(s + k * 1000 + 999, "t1_step_end", 1, k, -1);
    end
    push(s + 8000, "t1_end", 0, 0, 0);
    dq.push_back(s + 8000);
    push(s,       "t2_note_start", 1, 0, 0);
    push(s + 112, "t2_before_rise", 1, 0, 0);
    push(s + 113, "t2_first_rise", 1, 0, 1);
    push(s + 225, "t2_high_end", 1, 0, 1);
    push(s + 226, "t2_fall", 1, 0, 0);
    push(s + 339, "t2_second_rise", 1, 0, 1);
    push(s + 4899, "t6_pre_gap", 1, 4, 1);
`ifdef NOTE_GAP_EN
    push(s + 4900, "t6_gap_start", 1, 4, 0);
    push(s + 4980, "t6_gap_mid", 1, 4, 0);
    push(s + 4999, "t6_gap_end", 1, 4, 0);
`else
    push(s + 4980, "t6_legato_mid", 1, 4, 1);
    push(s + 4999, "t6_legato_end", 1, 4, 1);
`endif
    push(s + 5000, "t6_s5_start", 1, 5, 0);
    push(s + 5074, "t6_s5_before_rise", 1, 5, 0);
    push(s + 5075, "t6_s5_rise", 1, 5, 1);
    wait_until(s + 8005);

    // Retrigger into song 1 during step 3 of song 0, then song 1 to completion.
    push(cyc, "t4_pre", 0, 0, 0);
    do_start(1'b0, s);
    push(s + 3000, "t4_step3", 1, 3, -1);
    wait_until(s + 3499);
    push(s + 3499, "t4_pre_retrig", 1, 3, -1);
    do_start(1'b1, r);
    push(r, "t4_retrig", 1, 0, 0);
    push(r + 46,   "t3_s0_low", 1, 0, 0);
    push(r + 47,   "t3_s0_rise", 1, 0, 1);
    push(r + 93,   "t3_s0_high", 1, 0, 1);
    push(r + 94,   "t3_s0_fall", 1, 0, 0);
    push(r + 141,  "t3_s0_rise2", 1, 0, 1);
    push(r + 1000, "t3_rest1_start", 1, 1, 0);
    push(r + 1047, "t3_rest1_a", 1, 1, 0);
    push(r + 1500, "t3_rest1_b", 1, 1, 0);
    push(r + 1999, "t3_rest1_end", 1, 1, 0);
    push(r + 2047, "t3_s2_rise", 1, 2, 1);
    push(r + 3500, "t3_rest3", 1, 3, 0);
    push(r + 6047, "t3_s6_rise", 1, 6, 1);
    push(r + 7500, "t3_rest7", 1, 7, 0);
    push(r + 7999, "t4_last", 1, 7, 0);
    push(r + 8000, "t4_end", 0, 0, 0);
    dq.push_back(r + 8000);
    wait_until(r + 8005);

    // Simultaneous start and stop mid-song: stop wins.
    do_start(1'b0, s);
    p = s + 2300;
    wait_until(p - 1);
    push(p - 1, "t5_pre", 1, 2, 1);
    song_sel = 1'b1;
    start    = 1'b1;
    stop     = 1'b1;
    tick();
    start    = 1'b0;
    stop     = 1'b0;
    push(p, "t5_abort", 0, 0, 0);
    push(p + 500, "t5_stay_idle", 0, 0, 0);
    wait_until(p + 600);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    push(cyc, "t5_stop_in_idle", 0, 0, 0);
    tick();

    // Synchronous reset mid-note.
    do_start(1'b1, s);
    p = s + 50;
    wait_until(p - 1);
    push(p - 1, "t5_rst_pre", 1, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(p, "t5_rst", 0, 0, 0);
    wait_until(p + 10);

    // Start on the final tick of a song retriggers with no done; then a plain stop.
    do_start(1'b1, s);
    push(s + 7000, "t7_step7", 1, 7, 0);
    wait_until(s + 7999);
    push(s + 7999, "t7_last_tick", 1, 7, -1);
    do_start(1'b0, r);
    push(r, "t7_retrig", 1, 0, 0);
    push(r + 113, "t7_tone", 1, 0, 1);
    wait_until(r + 200);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    push(r + 201, "t7_stop", 0, 0, 0);
    wait_until(r + 210);

    tick();
    tick();
    chk("exp_queue_drained", qc.size(), 0);
    chk("done_queue_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
